// File: rtl/chan_regfifo.sv
// Channel application block: NUM_REGS byte registers, a loopback FIFO and a synchronised switch channel.
// Optional status/flush channel at FIFO_CHAN+1 is enabled by defining CHAN_STATUS_EN.
module chan_regfifo #(
  parameter int NUM_REGS   = 8,
  parameter int FIFO_CHAN  = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int SW_CHAN    = 65,
  parameter int IO_WIDTH   = 8
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [6:0]          chanAddr_in,
  input  logic [7:0]          h2fData_in,
  input  logic                h2fValid_in,
  output logic                h2fReady_out,
  output logic [7:0]          f2hData_out,
  output logic                f2hValid_out,
  input  logic                f2hReady_in,
  output logic [IO_WIDTH-1:0] led_out,
  input  logic [IO_WIDTH-1:0] sw_in,
  output logic [5:0]          fifoCount_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] FIFO_ADDR = 7'(FIFO_CHAN);
  localparam logic [6:0] SW_ADDR   = 7'(SW_CHAN);
  localparam logic [7:0] NREG      = 8'(NUM_REGS);
  localparam logic [5:0] DEPTH     = 6'(FIFO_DEPTH);

  initial begin
    if (FIFO_CHAN < NUM_REGS || SW_CHAN < NUM_REGS)
      $error("chan_regfifo: FIFO_CHAN/SW_CHAN overlaps the register range");
  end

  logic [7:0]          r_regs [NUM_REGS];
  logic [7:0]          r_fifo [FIFO_DEPTH];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;
  logic [5:0]          r_count;
  logic [IO_WIDTH-1:0] r_swMeta;
  logic [IO_WIDTH-1:0] r_swSync;

  logic          w_isFifo;
  logic          w_isStat;
  logic          w_isSw;
  logic          w_isReg;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic [RW-1:0] w_regIdx;
  logic [7:0]    w_swExt;

  assign w_full   = (r_count == DEPTH);
  assign w_empty  = (r_count == 6'd0);
  assign w_isFifo = (chanAddr_in == FIFO_ADDR);
`ifdef CHAN_STATUS_EN
  assign w_isStat = !w_isFifo && (chanAddr_in == 7'(FIFO_CHAN + 1));
`else
  assign w_isStat = 1'b0;
`endif
  assign w_isSw   = !w_isFifo && !w_isStat && (chanAddr_in == SW_ADDR);
  assign w_isReg  = !w_isFifo && !w_isStat && !w_isSw && ({1'b0, chanAddr_in} < NREG);
  assign w_regIdx = chanAddr_in[RW-1:0];

  assign h2fReady_out  = w_isFifo ? !w_full  : 1'b1;
  assign f2hValid_out  = w_isFifo ? !w_empty : 1'b1;
  assign w_wr          = h2fValid_in && h2fReady_out;
  assign w_push        = w_wr && w_isFifo;
  assign w_pop         = f2hValid_out && f2hReady_in && w_isFifo;
  assign led_out       = r_regs[0][IO_WIDTH-1:0];
  assign fifoCount_out = r_count;

  always_comb begin
    w_swExt = '0;
    w_swExt[IO_WIDTH-1:0] = r_swSync;
  end

  // Read mux follows the address precedence: FIFO, status, switches, registers, else zero.
  always_comb begin
    f2hData_out = 8'h00;
    if (w_isFifo)
      f2hData_out = w_empty ? 8'h00 : r_fifo[r_rdPtr];
    else if (w_isStat)
      f2hData_out = {w_full, w_empty, r_count};
    else if (w_isSw)
      f2hData_out = w_swExt;
    else if (w_isReg)
      f2hData_out = r_regs[w_regIdx];
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else if (w_wr && w_isReg) begin
      r_regs[w_regIdx] <= h2fData_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_swMeta <= '0;
      r_swSync <= '0;
    end else begin
      r_swMeta <= sw_in;
      r_swSync <= r_swMeta;
    end
  end

  // Occupancy is tracked separately from the pointers so full and empty are unambiguous.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= 6'd0;
    end
`ifdef CHAN_STATUS_EN
    else if (w_wr && w_isStat) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= 6'd0;
    end
`endif
    else begin
      if (w_push) begin
        r_fifo[r_wrPtr] <= h2fData_in;
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      if (w_pop)
        r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 6'd1;
        2'b01:   r_count <= r_count - 6'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_regfifo.sv
// Directed self-checking bench for chan_regfifo with default parameters.
// Status-channel steps are compiled in when CHAN_STATUS_EN is defined.
module tb_chan_regfifo;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b0;
  logic [6:0] chanAddr_in = 7'd0;
  logic [7:0] h2fData_in = 8'h00;
  logic       h2fValid_in = 1'b0;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in = 1'b0;
  logic [7:0] led_out;
  logic [7:0] sw_in = 8'h00;
  logic [5:0] fifoCount_out;

  int nChecks = 0;
  int nPass   = 0;

  chan_regfifo dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .chanAddr_in   (chanAddr_in),
    .h2fData_in    (h2fData_in),
    .h2fValid_in   (h2fValid_in),
    .h2fReady_out  (h2fReady_out),
    .f2hData_out   (f2hData_out),
    .f2hValid_out  (f2hValid_out),
    .f2hReady_in   (f2hReady_in),
    .led_out       (led_out),
    .sw_in         (sw_in),
    .fifoCount_out (fifoCount_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
  endtask

  // One write transfer on the next rising edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [6:0] addr, input logic [7:0] data);
    chanAddr_in = addr;
    h2fData_in  = data;
    h2fValid_in = 1'b1;
    @(posedge clk_in);
    #1;
    h2fValid_in = 1'b0;
  endtask

  // Checks the head byte, then pops it.
  task automatic popCheck(input string tag, input logic [7:0] expected);
    chanAddr_in = 7'd64;
    f2hReady_in = 1'b1;
    #1;
    checkOutput({tag, "_valid"}, {7'd0, f2hValid_out}, 8'h01);
    checkOutput(tag, f2hData_out, expected);
    @(posedge clk_in);
    #1;
    f2hReady_in = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [6:0] addr, input logic [7:0] expected);
    chanAddr_in = addr;
    #1;
    checkOutput({tag, "_valid"}, {7'd0, f2hValid_out}, 8'h01);
    checkOutput(tag, f2hData_out, expected);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_led", led_out, 8'h00);
    checkOutput("reset_count", {2'b00, fifoCount_out}, 8'h00);
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 8; i++) readCheck($sformatf("reset_reg%0d", i), 7'(i), 8'h00);

    checkOutput("led_before_write", led_out, 8'h00);
    applyStimulus(7'd0, 8'hA5);
    checkOutput("led_after_write", led_out, 8'hA5);
    applyStimulus(7'd7, 8'h3C);
    readCheck("read_ch7", 7'd7, 8'h3C);
    readCheck("read_ch0", 7'd0, 8'hA5);
    applyStimulus(7'd100, 8'h77);
    readCheck("read_ch100", 7'd100, 8'h00);
    checkOutput("ready_ch100", {7'd0, h2fReady_out}, 8'h01);

    chanAddr_in = 7'd64;
    #1;
    checkOutput("empty_valid", {7'd0, f2hValid_out}, 8'h00);
    checkOutput("empty_data", f2hData_out, 8'h00);
    for (int i = 0; i < 16; i++) applyStimulus(7'd64, 8'(i));
    checkOutput("full_count", {2'b00, fifoCount_out}, 8'd16);
    checkOutput("full_ready", {7'd0, h2fReady_out}, 8'h00);
    h2fData_in  = 8'hEE;
    h2fValid_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    h2fValid_in = 1'b0;
    checkOutput("stall_count", {2'b00, fifoCount_out}, 8'd16);
    for (int i = 0; i < 16; i++) popCheck($sformatf("drain%0d", i), 8'(i));
    checkOutput("drained_valid", {7'd0, f2hValid_out}, 8'h00);
    checkOutput("drained_count", {2'b00, fifoCount_out}, 8'd0);

    for (int i = 0; i < 10; i++) applyStimulus(7'd64, 8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) popCheck($sformatf("wrapA%0d", i), 8'h20 + 8'(i));
    for (int i = 0; i < 12; i++) applyStimulus(7'd64, 8'h40 + 8'(i));
    checkOutput("wrap_count", {2'b00, fifoCount_out}, 8'd12);
    for (int i = 0; i < 12; i++) popCheck($sformatf("wrapB%0d", i), 8'h40 + 8'(i));

    for (int i = 0; i < 5; i++) applyStimulus(7'd64, 8'h50 + 8'(i));
    f2hReady_in = 1'b1;
    applyStimulus(7'd64, 8'h99);
    f2hReady_in = 1'b0;
    checkOutput("simul_count", {2'b00, fifoCount_out}, 8'd5);
    checkOutput("simul_head", f2hData_out, 8'h51);
    popCheck("simul_d0", 8'h51);
    popCheck("simul_d1", 8'h52);
    popCheck("simul_d2", 8'h53);
    popCheck("simul_d3", 8'h54);
    popCheck("simul_d4", 8'h99);

    applyStimulus(7'd64, 8'h11);
    applyStimulus(7'd64, 8'h22);
    reset_in = 1'b0;
    #2;
    checkOutput("midreset_count", {2'b00, fifoCount_out}, 8'd0);
    checkOutput("midreset_led", led_out, 8'h00);
    reset_in = 1'b1;
    @(posedge clk_in);
    #1;
    chanAddr_in = 7'd64;
    #1;
    checkOutput("midreset_valid", {7'd0, f2hValid_out}, 8'h00);
    readCheck("midreset_ch7", 7'd7, 8'h00);

`ifdef CHAN_STATUS_EN
    for (int i = 0; i < 3; i++) applyStimulus(7'd64, 8'h60 + 8'(i));
    readCheck("status_3", 7'd65, 8'h03);
    for (int i = 0; i < 13; i++) applyStimulus(7'd64, 8'h70 + 8'(i));
    readCheck("status_full", 7'd65, 8'h90);
    applyStimulus(7'd65, 8'h5C);
    checkOutput("flush_count", {2'b00, fifoCount_out}, 8'd0);
    readCheck("status_empty", 7'd65, 8'h40);
`else
    applyStimulus(7'd0, 8'hC3);
    sw_in = 8'h5A;
    @(posedge clk_in);
    #1;
    readCheck("sw_one_clock", 7'd65, 8'h00);
    @(posedge clk_in);
    #1;
    readCheck("sw_two_clocks", 7'd65, 8'h5A);
    applyStimulus(7'd65, 8'hFF);
    checkOutput("sw_write_led", led_out, 8'hC3);
    readCheck("sw_after_write", 7'd65, 8'h5A);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
